// File: rtl/reset_sequencer_if.sv
// Reset-sequencer output bundle: software request in, staged resets and status out.
// The sequencer takes the master side; the reset consumer takes the slave side.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  sw_rst_req_i;
  logic [NUM_STAGES-1:0] rst_n_o;
  logic                  done_o;
  logic [1:0]            state_o;

  modport master (
    input  sw_rst_req_i,
    output rst_n_o,
    output done_o,
    output state_o
  );

  modport slave (
    output sw_rst_req_i,
    input  rst_n_o,
    input  done_o,
    input  state_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: asserts all stage resets at once and releases them in order
// 0..NUM_STAGES-1, after a synchronised and stretched deassertion.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned GAP         = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  reset_sequencer_if.master bus
);

  localparam int unsigned CntMax = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam int unsigned IdxW   = $clog2(NUM_STAGES) + 1;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StStretch = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;
  logic                   hold;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [NUM_STAGES-1:0]  rst_n_q;
  logic                   done_q;

  // Async set, synchronous release of the board reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];
  assign hold     = rst_sync | bus.sw_rst_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else if (hold) begin
      state_q <= rst_sync ? StHold : StStretch;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        // The first hold-free edge in HOLD counts as stretch count 0.
        StHold, StStretch: begin
          if (cnt_q == CntW'(STRETCH - 1)) begin
            rst_n_q[0] <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= IdxW'(1);
            if (NUM_STAGES == 1) begin
              state_q <= StRun;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRelease;
            end
          end else begin
            cnt_q   <= cnt_q + CntW'(1);
            state_q <= StStretch;
          end
        end
        StRelease: begin
          if (cnt_q == CntW'(GAP - 1)) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
              if (idx_q == IdxW'(k)) begin
                rst_n_q[k] <= 1'b1;
              end
            end
            cnt_q <= '0;
            idx_q <= idx_q + IdxW'(1);
            if (idx_q == IdxW'(NUM_STAGES - 1)) begin
              state_q <= StRun;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRun: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= StHold;
        end
      endcase
    end
  end

  assign bus.rst_n_o = rst_n_q;
  assign bus.done_o  = done_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing scenarios plus random requests/resets,
// checked against a model that counts edges since the last reset-holding edge.
module tb_reset_sequencer;

  localparam int SyncN = 2;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(4)) ifa ();
  reset_sequencer_if #(.NUM_STAGES(1)) ifb ();

  reset_sequencer #(
    .NUM_STAGES (4),
    .SYNC_STAGES(2),
    .STRETCH    (16),
    .GAP        (8)
  ) u_dut_a (
    .clk_i(clk),
    .rst_i(rst_a),
    .bus  (ifa.master)
  );

  reset_sequencer #(
    .NUM_STAGES (1),
    .SYNC_STAGES(2),
    .STRETCH    (1),
    .GAP        (1)
  ) u_dut_b (
    .clk_i(clk),
    .rst_i(rst_b),
    .bus  (ifb.master)
  );

  // fall_cnt: edges since rst_i fell; since: edges since the last hold edge (-1 in reset).
  typedef struct {
    int fall_cnt;
    int since;
    bit by_async;
  } mdl_t;

  mdl_t ma, mb;
  int   checks = 0;
  int   failures = 0;
  int   rise[4];
  int   done_at;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.fall_cnt = 0;
    m.since    = -1;
    m.by_async = 1'b1;
    return m;
  endfunction

  function automatic mdl_t mdl_edge(mdl_t m, logic rst, logic sw);
    mdl_t r;
    bit   sync_hi;
    r = m;
    if (rst) begin
      r = mdl_reset();
    end else begin
      r.fall_cnt = m.fall_cnt + 1;
      sync_hi    = (r.fall_cnt <= SyncN);
      if (sync_hi || sw) begin
        r.since    = 0;
        r.by_async = sync_hi;
      end else if (m.since >= 0) begin
        r.since = m.since + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_rst_n(mdl_t m, int ns, int st, int gap);
    logic [31:0] r;
    r = '0;
    if (m.since >= 0) begin
      for (int k = 0; k < ns; k++) begin
        if (m.since >= st + k * gap) r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_done(mdl_t m, int ns, int st, int gap);
    return (m.since >= 0 && m.since >= st + (ns - 1) * gap) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_state(mdl_t m, int ns, int st, int gap);
    if (m.since < 0) return 32'd0;
    if (m.since < st) return (m.since == 0 && m.by_async) ? 32'd0 : 32'd1;
    if (m.since >= st + (ns - 1) * gap) return 32'd3;
    return 32'd2;
  endfunction

  function automatic logic [31:0] contiguous(logic [31:0] r);
    logic [32:0] w;
    w = {1'b0, r};
    return ((w & (w + 33'd1)) == 33'd0) ? 32'd1 : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_rst_n", 32'(ifa.rst_n_o), exp_rst_n(ma, 4, 16, 8));
    chk("a_done", 32'(ifa.done_o), exp_done(ma, 4, 16, 8));
    chk("a_state", 32'(ifa.state_o), exp_state(ma, 4, 16, 8));
    chk("a_contig", contiguous(32'(ifa.rst_n_o)), 32'd1);
    chk("b_rst_n", 32'(ifb.rst_n_o), exp_rst_n(mb, 1, 1, 1));
    chk("b_done", 32'(ifb.done_o), exp_done(mb, 1, 1, 1));
    chk("b_state", 32'(ifb.state_o), exp_state(mb, 1, 1, 1));
  endtask

  task automatic step();
    @(posedge clk);
    ma = mdl_edge(ma, rst_a, ifa.sw_rst_req_i);
    mb = mdl_edge(mb, rst_b, ifb.sw_rst_req_i);
    #1;
    check_all();
  endtask

  task automatic set_rst_a(input logic v);
    rst_a = v;
    if (v) ma = mdl_reset();
  endtask

  task automatic set_rst_b(input logic v);
    rst_b = v;
    if (v) mb = mdl_reset();
  endtask

  task automatic run_record_a(input int n);
    for (int k = 0; k < 4; k++) rise[k] = -1;
    done_at = -1;
    for (int e = 1; e <= n; e++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        if (rise[k] < 0 && ifa.rst_n_o[k]) rise[k] = e;
      end
      if (done_at < 0 && ifa.done_o) done_at = e;
    end
  endtask

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    ifa.sw_rst_req_i = 1'b0;
    ifb.sw_rst_req_i = 1'b0;

    // Power-on: reset held for five cycles, then released.
    #1;
    check_all();
    for (int i = 0; i < 5; i++) step();
    set_rst_a(1'b0);
    run_record_a(45);
    chk("por_rise0", 32'(rise[0]), 32'd18);
    chk("por_rise1", 32'(rise[1]), 32'd26);
    chk("por_rise2", 32'(rise[2]), 32'd34);
    chk("por_rise3", 32'(rise[3]), 32'd42);
    chk("por_done", 32'(done_at), 32'd42);

    // Async pulse mid-release, between E30 and E31.
    set_rst_a(1'b1);
    step();
    step();
    set_rst_a(1'b0);
    for (int i = 0; i < 30; i++) step();
    #2;
    set_rst_a(1'b1);
    #1;
    chk("pulse_rst_n", 32'(ifa.rst_n_o), 32'd0);
    chk("pulse_done", 32'(ifa.done_o), 32'd0);
    check_all();
    #2;
    set_rst_a(1'b0);
    run_record_a(45);
    chk("pulse_rise0", 32'(rise[0]), 32'd18);
    chk("pulse_rise3", 32'(rise[3]), 32'd42);
    chk("pulse_done_at", 32'(done_at), 32'd42);

    // One-cycle software reset from RUN.
    ifa.sw_rst_req_i = 1'b1;
    step();
    ifa.sw_rst_req_i = 1'b0;
    chk("sw_cleared", 32'(ifa.rst_n_o), 32'd0);
    run_record_a(45);
    chk("sw_rise0", 32'(rise[0]), 32'd16);
    chk("sw_rise3", 32'(rise[3]), 32'd40);
    chk("sw_done_at", 32'(done_at), 32'd40);

    // Software request held for 20 cycles.
    ifa.sw_rst_req_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("held_state", 32'(ifa.state_o), 32'd1);
    chk("held_rst_n", 32'(ifa.rst_n_o), 32'd0);
    ifa.sw_rst_req_i = 1'b0;
    run_record_a(45);
    chk("held_rise0", 32'(rise[0]), 32'd16);

    // Request lands on the edge where stage 2 would release.
    ifa.sw_rst_req_i = 1'b1;
    step();
    ifa.sw_rst_req_i = 1'b0;
    for (int i = 0; i < 31; i++) step();
    chk("coll_before", 32'(ifa.rst_n_o), 32'd3);
    ifa.sw_rst_req_i = 1'b1;
    step();
    ifa.sw_rst_req_i = 1'b0;
    chk("coll_after", 32'(ifa.rst_n_o), 32'd0);
    run_record_a(45);
    chk("coll_rise2", 32'(rise[2]), 32'd32);

    // Minimal configuration: one stage, stretch 1, gap 1.
    set_rst_b(1'b0);
    done_at = -1;
    rise[0] = -1;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (rise[0] < 0 && ifb.rst_n_o[0]) rise[0] = e;
      if (done_at < 0 && ifb.done_o) done_at = e;
    end
    chk("min_rise0", 32'(rise[0]), 32'd3);
    chk("min_done", 32'(done_at), 32'd3);

    // Random requests and async resets on both instances.
    for (int i = 0; i < 3000; i++) begin
      ifa.sw_rst_req_i = ($urandom_range(0, 39) == 0);
      ifb.sw_rst_req_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) set_rst_a(1'b1);
      else if (rst_a && $urandom_range(0, 2) == 0) set_rst_a(1'b0);
      if ($urandom_range(0, 99) == 0) set_rst_b(1'b1);
      else if (rst_b && $urandom_range(0, 1) == 0) set_rst_b(1'b0);
      if (rst_a || rst_b) begin
        #1;
        check_all();
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
